// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

  localparam int ADDR_LINE_REG = 5;
  localparam int D_SIZE        = 32;

  // One in-flight writer tracked by the scoreboard
  typedef struct packed {
    logic                     v;
    logic [ADDR_LINE_REG-1:0] rd;
    logic                     wr;
    logic                     ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_RUN   = 2'd1,
    PS_DRAIN = 2'd2,
    PS_DONE  = 2'd3
  } pipe_state_e;

  // Plain-vector state codes so the state register stays a simple logic vector
  localparam logic [1:0] ST_IDLE  = PS_IDLE;
  localparam logic [1:0] ST_RUN   = PS_RUN;
  localparam logic [1:0] ST_DRAIN = PS_DRAIN;
  localparam logic [1:0] ST_DONE  = PS_DONE;

  // Forwarding select encodings: 0 reads the register file, k+1 takes entry k
  localparam int FSEL_REGFILE    = 0;
  localparam int FSEL_ENTRY_BASE = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/control bus between the core pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 3
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int FSEL_W = $clog2(NUM_STAGES + 1);

  logic                     valid;
  logic                     opr_finished;
  logic                     id_valid;
  logic [ADDR_LINE_REG-1:0] id_rs_addr;
  logic [ADDR_LINE_REG-1:0] id_rt_addr;
  logic                     id_uses_rs;
  logic                     id_uses_rt;
  logic [ADDR_LINE_REG-1:0] id_rd_addr;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     ex_branch_taken;

  logic                     stall;
  logic                     bubble;
  logic                     flush_if_id;
  logic [FSEL_W-1:0]        fwd_sel_rs;
  logic [FSEL_W-1:0]        fwd_sel_rt;
  logic [FSEL_W-1:0]        inflight_cnt;
  logic                     done;

  // Pipeline side: drives decode information, consumes control
  modport master (
    output valid, opr_finished, id_valid, id_rs_addr, id_rt_addr,
           id_uses_rs, id_uses_rt, id_rd_addr, id_reg_write, id_mem_read,
           ex_branch_taken,
    input  stall, bubble, flush_if_id, fwd_sel_rs, fwd_sel_rt,
           inflight_cnt, done
  );

  // Controller side
  modport slave (
    input  valid, opr_finished, id_valid, id_rs_addr, id_rt_addr,
           id_uses_rs, id_uses_rt, id_rd_addr, id_reg_write, id_mem_read,
           ex_branch_taken,
    output stall, bubble, flush_if_id, fwd_sel_rs, fwd_sel_rt,
           inflight_cnt, done
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority match of one decode source register against the writer scoreboard.
module pipe_hazard_ctrl_fwd_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int FSEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  sb_entry_t                i_sb [NUM_STAGES],
  input  logic [ADDR_LINE_REG-1:0] i_src,
  input  logic                     i_uses,
  output logic                     o_hit,
  output logic [FSEL_W-1:0]        o_idx,
  output logic                     o_loadBlock
);

  // Walk oldest to youngest so the lowest-index (youngest) writer wins
  always_comb begin
    o_hit       = 1'b0;
    o_idx       = '0;
    o_loadBlock = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (i_uses && (i_src != '0) && i_sb[k].v && i_sb[k].wr && (i_sb[k].rd == i_src)) begin
        o_hit       = 1'b1;
        o_idx       = FSEL_W'(k);
        o_loadBlock = i_sb[k].ld && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: writer scoreboard, forwarding selects, load-use stall,
// branch flush and the idle/run/drain/done program sequencer.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int FSEL_W = $clog2(NUM_STAGES + 1);

  sb_entry_t         r_sb      [NUM_STAGES];
  sb_entry_t         w_sbNext  [NUM_STAGES];
  logic [FSEL_W-1:0] r_inflightCnt;
  logic [FSEL_W-1:0] w_cntNext;
  logic [1:0]        r_state;
  logic [1:0]        w_stateNext;

  logic              w_rsHit;
  logic [FSEL_W-1:0] w_rsIdx;
  logic              w_rsBlock;
  logic              w_rtHit;
  logic [FSEL_W-1:0] w_rtIdx;
  logic              w_rtBlock;

  logic              w_run;
  logic              w_loadStall;
  logic              w_branch;
  logic              w_stall;
  logic              w_issue;

  pipe_hazard_ctrl_fwd_match #(
    .NUM_STAGES(NUM_STAGES),
    .LOAD_LAT  (LOAD_LAT),
    .FSEL_W    (FSEL_W)
  ) u_matchRs (
    .i_sb       (r_sb),
    .i_src      (bus.id_rs_addr),
    .i_uses     (bus.id_uses_rs),
    .o_hit      (w_rsHit),
    .o_idx      (w_rsIdx),
    .o_loadBlock(w_rsBlock)
  );

  pipe_hazard_ctrl_fwd_match #(
    .NUM_STAGES(NUM_STAGES),
    .LOAD_LAT  (LOAD_LAT),
    .FSEL_W    (FSEL_W)
  ) u_matchRt (
    .i_sb       (r_sb),
    .i_src      (bus.id_rt_addr),
    .i_uses     (bus.id_uses_rt),
    .o_hit      (w_rtHit),
    .o_idx      (w_rtIdx),
    .o_loadBlock(w_rtBlock)
  );

  // A taken branch beats a load-use stall so fetch can move to the target
  assign w_run       = (r_state == ST_RUN);
  assign w_loadStall = w_run && (w_rsBlock || w_rtBlock);
  assign w_branch    = w_run && bus.ex_branch_taken;
  assign w_stall     = !w_run || (w_loadStall && !w_branch);
  assign w_issue     = w_run && bus.id_valid && !w_stall && !bus.ex_branch_taken;

  assign bus.stall        = w_stall;
  assign bus.bubble       = (r_state == ST_DRAIN) || w_loadStall || w_branch;
  assign bus.flush_if_id  = w_branch;
  assign bus.fwd_sel_rs   = (w_rsHit && !w_rsBlock) ? FSEL_W'(FSEL_ENTRY_BASE) + w_rsIdx
                                                    : FSEL_W'(FSEL_REGFILE);
  assign bus.fwd_sel_rt   = (w_rtHit && !w_rtBlock) ? FSEL_W'(FSEL_ENTRY_BASE) + w_rtIdx
                                                    : FSEL_W'(FSEL_REGFILE);
  assign bus.inflight_cnt = r_inflightCnt;
  assign bus.done         = (r_state == ST_DONE);

  // Next scoreboard: shift toward WB, insert the issued instruction or a bubble
  always_comb begin
    w_sbNext[0] = '0;
    if (w_issue) begin
      w_sbNext[0].v  = 1'b1;
      w_sbNext[0].rd = bus.id_rd_addr;
      w_sbNext[0].wr = bus.id_reg_write;
      w_sbNext[0].ld = bus.id_mem_read;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_sbNext[i] = r_sb[i-1];
    end
  end

  // Population count of the valid bits the scoreboard is about to hold
  always_comb begin
    w_cntNext = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_cntNext = w_cntNext + FSEL_W'(w_sbNext[i].v);
    end
  end

  // Scoreboard and in-flight count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_sb[i] <= '0;
      end
      r_inflightCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_sb[i] <= w_sbNext[i];
      end
      r_inflightCnt <= w_cntNext;
    end
  end

  // Program sequencing: end-of-program wins over a fresh start while running
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (bus.valid)             w_stateNext = ST_RUN;
      ST_RUN:   if (bus.opr_finished)      w_stateNext = ST_DRAIN;
      ST_DRAIN: if (r_inflightCnt == '0)   w_stateNext = ST_DONE;
      ST_DONE:  if (bus.valid)             w_stateNext = ST_RUN;
      default:                             w_stateNext = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one DUT with LOAD_LAT=1, one with LOAD_LAT=2.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   errCount;
  int   checkCount;

  pipe_hazard_ctrl_if #(.NUM_STAGES(3)) bus ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(3)) bus2 ();

  pipe_hazard_ctrl #(.NUM_STAGES(3), .LOAD_LAT(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(3), .LOAD_LAT(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic idv, input int rs, input int rt, input logic urs,
                               input logic urt, input int rd, input logic wr, input logic ld);
    bus.id_valid     = idv;
    bus.id_rs_addr   = ADDR_LINE_REG'(rs);
    bus.id_rt_addr   = ADDR_LINE_REG'(rt);
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.id_rd_addr   = ADDR_LINE_REG'(rd);
    bus.id_reg_write = wr;
    bus.id_mem_read  = ld;
  endtask

  task automatic applyStimulus2(input logic idv, input int rs, input int rt, input logic urs,
                                input logic urt, input int rd, input logic wr, input logic ld);
    bus2.id_valid     = idv;
    bus2.id_rs_addr   = ADDR_LINE_REG'(rs);
    bus2.id_rt_addr   = ADDR_LINE_REG'(rt);
    bus2.id_uses_rs   = urs;
    bus2.id_uses_rt   = urt;
    bus2.id_rd_addr   = ADDR_LINE_REG'(rd);
    bus2.id_reg_write = wr;
    bus2.id_mem_read  = ld;
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus2(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL rst_stall: got %0d want 1", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b0) begin errCount++; $display("[TB] FAIL rst_bubble: got %0d want 0", bus.bubble); end
    checkCount++; if (bus.flush_if_id !== 1'b0) begin errCount++; $display("[TB] FAIL rst_flush: got %0d want 0", bus.flush_if_id); end
    checkCount++; if (bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL rst_done: got %0d want 0", bus.done); end
    checkCount++; if (bus.inflight_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL rst_cnt: got %0d want 0", bus.inflight_cnt); end
    checkCount++; if (bus.fwd_sel_rs !== 2'd0) begin errCount++; $display("[TB] FAIL rst_fwd_rs: got %0d want 0", bus.fwd_sel_rs); end
    @(negedge clk); reset = 1'b1; #1;
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL idle_stall: got %0d want 1", bus.stall); end
    @(negedge clk); bus.valid = 1'b1; bus2.valid = 1'b1; #1;
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL idle_valid_stall: got %0d want 1", bus.stall); end
    @(negedge clk); bus.valid = 1'b0; bus2.valid = 1'b0; #1;
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL run_stall: got %0d want 0", bus.stall); end
    checkCount++; if (bus2.stall !== 1'b0) begin errCount++; $display("[TB] FAIL run2_stall: got %0d want 0", bus2.stall); end
  endtask

  task automatic test_forwarding();
    @(negedge clk); applyStimulus(1, 1, 2, 1, 1, 3, 1, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd0) begin errCount++; $display("[TB] FAIL fwd_add_rs: got %0d want 0", bus.fwd_sel_rs); end
    @(negedge clk); applyStimulus(0, 3, 5, 1, 1, 4, 1, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL fwd_ex_rs: got %0d want 1", bus.fwd_sel_rs); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd0) begin errCount++; $display("[TB] FAIL fwd_ex_rt: got %0d want 0", bus.fwd_sel_rt); end
    @(negedge clk); applyStimulus(1, 3, 5, 1, 1, 4, 1, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd2) begin errCount++; $display("[TB] FAIL fwd_mem_rs: got %0d want 2", bus.fwd_sel_rs); end
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL fwd_mem_stall: got %0d want 0", bus.stall); end
    @(negedge clk); applyStimulus(0, 4, 3, 1, 1, 9, 0, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL fwd_r4_rs: got %0d want 1", bus.fwd_sel_rs); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd3) begin errCount++; $display("[TB] FAIL fwd_wb_rt: got %0d want 3", bus.fwd_sel_rt); end
    @(negedge clk); applyStimulus(0, 3, 4, 1, 1, 9, 0, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd0) begin errCount++; $display("[TB] FAIL fwd_retired_rs: got %0d want 0", bus.fwd_sel_rs); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd2) begin errCount++; $display("[TB] FAIL fwd_r4_rt: got %0d want 2", bus.fwd_sel_rt); end
    @(negedge clk); applyStimulus(1, 0, 4, 1, 1, 0, 1, 0); #1;
    checkCount++; if (bus.fwd_sel_rt !== 2'd3) begin errCount++; $display("[TB] FAIL fwd_r4_wb_rt: got %0d want 3", bus.fwd_sel_rt); end
    @(negedge clk); applyStimulus(1, 0, 0, 1, 1, 7, 1, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd0) begin errCount++; $display("[TB] FAIL fwd_r0_rs: got %0d want 0", bus.fwd_sel_rs); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd0) begin errCount++; $display("[TB] FAIL fwd_r0_rt: got %0d want 0", bus.fwd_sel_rt); end
    @(negedge clk); applyStimulus(1, 7, 7, 1, 0, 7, 1, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL fwd_r7_rs: got %0d want 1", bus.fwd_sel_rs); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd0) begin errCount++; $display("[TB] FAIL fwd_unused_rt: got %0d want 0", bus.fwd_sel_rt); end
    idleCycles(0); #1;
    applyStimulus(0, 7, 7, 1, 1, 0, 0, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL fwd_youngest_rs: got %0d want 1", bus.fwd_sel_rs); end
    checkCount++; if (bus.inflight_cnt !== 2'd3) begin errCount++; $display("[TB] FAIL fwd_cnt: got %0d want 3", bus.inflight_cnt); end
    idleCycles(3);
  endtask

  task automatic test_load_use();
    @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 6, 1, 1); #1;
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu_lw_stall: got %0d want 0", bus.stall); end
    @(negedge clk); applyStimulus(1, 7, 6, 1, 1, 8, 1, 0); #1;
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL lu_stall: got %0d want 1", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b1) begin errCount++; $display("[TB] FAIL lu_bubble: got %0d want 1", bus.bubble); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd0) begin errCount++; $display("[TB] FAIL lu_fwd_rt: got %0d want 0", bus.fwd_sel_rt); end
    @(negedge clk); #1;
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu_release_stall: got %0d want 0", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b0) begin errCount++; $display("[TB] FAIL lu_release_bubble: got %0d want 0", bus.bubble); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd2) begin errCount++; $display("[TB] FAIL lu_release_rt: got %0d want 2", bus.fwd_sel_rt); end
    @(negedge clk); applyStimulus(1, 8, 0, 1, 0, 9, 1, 0); #1;
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu_after_stall: got %0d want 0", bus.stall); end
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL lu_after_rs: got %0d want 1", bus.fwd_sel_rs); end
    idleCycles(3);
    @(negedge clk); applyStimulus2(1, 1, 0, 1, 0, 6, 1, 1); #1;
    checkCount++; if (bus2.stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu2_lw_stall: got %0d want 0", bus2.stall); end
    @(negedge clk); applyStimulus2(1, 7, 6, 1, 1, 8, 1, 0); #1;
    checkCount++; if (bus2.stall !== 1'b1) begin errCount++; $display("[TB] FAIL lu2_stall1: got %0d want 1", bus2.stall); end
    checkCount++; if (bus2.bubble !== 1'b1) begin errCount++; $display("[TB] FAIL lu2_bubble1: got %0d want 1", bus2.bubble); end
    @(negedge clk); #1;
    checkCount++; if (bus2.stall !== 1'b1) begin errCount++; $display("[TB] FAIL lu2_stall2: got %0d want 1", bus2.stall); end
    checkCount++; if (bus2.fwd_sel_rt !== 2'd0) begin errCount++; $display("[TB] FAIL lu2_fwd_blocked: got %0d want 0", bus2.fwd_sel_rt); end
    @(negedge clk); #1;
    checkCount++; if (bus2.stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu2_release: got %0d want 0", bus2.stall); end
    checkCount++; if (bus2.fwd_sel_rt !== 2'd3) begin errCount++; $display("[TB] FAIL lu2_fwd_rt: got %0d want 3", bus2.fwd_sel_rt); end
    idleCycles(3);
  endtask

  task automatic test_branch();
    @(negedge clk); applyStimulus(1, 1, 0, 1, 0, 6, 1, 1);
    @(negedge clk); applyStimulus(1, 7, 6, 1, 1, 8, 1, 0); bus.ex_branch_taken = 1'b1; #1;
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL br_stall: got %0d want 0", bus.stall); end
    checkCount++; if (bus.flush_if_id !== 1'b1) begin errCount++; $display("[TB] FAIL br_flush: got %0d want 1", bus.flush_if_id); end
    checkCount++; if (bus.bubble !== 1'b1) begin errCount++; $display("[TB] FAIL br_bubble: got %0d want 1", bus.bubble); end
    @(negedge clk); bus.ex_branch_taken = 1'b0; applyStimulus(0, 8, 6, 1, 1, 0, 0, 0); #1;
    checkCount++; if (bus.fwd_sel_rs !== 2'd0) begin errCount++; $display("[TB] FAIL br_not_issued: got %0d want 0", bus.fwd_sel_rs); end
    checkCount++; if (bus.fwd_sel_rt !== 2'd2) begin errCount++; $display("[TB] FAIL br_lw_rt: got %0d want 2", bus.fwd_sel_rt); end
    checkCount++; if (bus.flush_if_id !== 1'b0) begin errCount++; $display("[TB] FAIL br_flush_single: got %0d want 0", bus.flush_if_id); end
    idleCycles(3);
  endtask

  task automatic test_drain();
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 2, 1, 0);
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 3, 1, 0); bus.opr_finished = 1'b1; bus.valid = 1'b1; #1;
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL dr_last_issue: got %0d want 0", bus.stall); end
    @(negedge clk); bus.opr_finished = 1'b0; bus.valid = 1'b0; applyStimulus(1, 3, 0, 1, 0, 5, 1, 0); #1;
    checkCount++; if (bus.inflight_cnt !== 2'd3) begin errCount++; $display("[TB] FAIL dr_cnt3: got %0d want 3", bus.inflight_cnt); end
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL dr_stall: got %0d want 1", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b1) begin errCount++; $display("[TB] FAIL dr_bubble: got %0d want 1", bus.bubble); end
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL dr_fwd_rs: got %0d want 1", bus.fwd_sel_rs); end
    @(negedge clk); #1;
    checkCount++; if (bus.inflight_cnt !== 2'd2) begin errCount++; $display("[TB] FAIL dr_cnt2: got %0d want 2", bus.inflight_cnt); end
    checkCount++; if (bus.fwd_sel_rs !== 2'd2) begin errCount++; $display("[TB] FAIL dr_fwd_rs2: got %0d want 2", bus.fwd_sel_rs); end
    @(negedge clk); #1;
    checkCount++; if (bus.inflight_cnt !== 2'd1) begin errCount++; $display("[TB] FAIL dr_cnt1: got %0d want 1", bus.inflight_cnt); end
    @(negedge clk); #1;
    checkCount++; if (bus.inflight_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL dr_cnt0: got %0d want 0", bus.inflight_cnt); end
    checkCount++; if (bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL dr_done_early: got %0d want 0", bus.done); end
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkCount++; if (bus.done !== 1'b1) begin errCount++; $display("[TB] FAIL dr_done: got %0d want 1", bus.done); end
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL done_stall: got %0d want 1", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b0) begin errCount++; $display("[TB] FAIL done_bubble: got %0d want 0", bus.bubble); end
    bus.valid = 1'b1;
    @(negedge clk); bus.valid = 1'b0; #1;
    checkCount++; if (bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL restart_done: got %0d want 0", bus.done); end
    checkCount++; if (bus.stall !== 1'b0) begin errCount++; $display("[TB] FAIL restart_stall: got %0d want 0", bus.stall); end
  endtask

  task automatic test_reset_in_drain();
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk); applyStimulus(1, 0, 0, 0, 0, 2, 1, 0); bus.opr_finished = 1'b1;
    @(negedge clk); bus.opr_finished = 1'b0; applyStimulus(0, 2, 0, 1, 0, 0, 0, 0); #1;
    checkCount++; if (bus.inflight_cnt !== 2'd2) begin errCount++; $display("[TB] FAIL rd_cnt2: got %0d want 2", bus.inflight_cnt); end
    checkCount++; if (bus.fwd_sel_rs !== 2'd1) begin errCount++; $display("[TB] FAIL rd_fwd_before: got %0d want 1", bus.fwd_sel_rs); end
    #1 reset = 1'b0; #1;
    checkCount++; if (bus.inflight_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL rd_cnt_cleared: got %0d want 0", bus.inflight_cnt); end
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL rd_stall: got %0d want 1", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b0) begin errCount++; $display("[TB] FAIL rd_bubble: got %0d want 0", bus.bubble); end
    checkCount++; if (bus.fwd_sel_rs !== 2'd0) begin errCount++; $display("[TB] FAIL rd_fwd_cleared: got %0d want 0", bus.fwd_sel_rs); end
    @(negedge clk); reset = 1'b1; #1;
    checkCount++; if (bus.stall !== 1'b1) begin errCount++; $display("[TB] FAIL rd_idle_stall: got %0d want 1", bus.stall); end
    checkCount++; if (bus.bubble !== 1'b0) begin errCount++; $display("[TB] FAIL rd_idle_bubble: got %0d want 0", bus.bubble); end
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    reset      = 1'b0;
    bus.valid = 1'b0; bus.opr_finished = 1'b0; bus.ex_branch_taken = 1'b0;
    bus2.valid = 1'b0; bus2.opr_finished = 1'b0; bus2.ex_branch_taken = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus2(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] starting pipe_hazard_ctrl bench");
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_drain();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control block for the five-stage core: hazard detection, forwarding selection, branch flush and program start/drain sequencing.
Holds a shift-register scoreboard of in-flight writers across NUM_STAGES post-decode stages (EX, MEM, WB by default).
Compares decode-stage source registers against the scoreboard to drive forwarding selects and load-use stalls.
Turns the testbench valid/opr_finished pair into a run/drain/done sequence.

Parameters:
NUM_STAGES, 3, post-decode stages tracked (entry 0 = EX, entry NUM_STAGES-1 = WB)
ADDR_LINE_REG, 5, register address width
LOAD_LAT, 1, load result not forwardable while the load sits in entries 0..LOAD_LAT-1
FSEL_W, $clog2(NUM_STAGES+1), forwarding select width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
valid  in  1  start program; level, sampled in IDLE/DONE
opr_finished  in  1  end of program; sampled in RUN
id_valid  in  1  decode stage holds a real instruction
id_rs_addr  in  ADDR_LINE_REG  decode rs
id_rt_addr  in  ADDR_LINE_REG  decode rt
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd_addr  in  ADDR_LINE_REG  decode destination
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX
stall  out  1  hold PC and IF/ID register
bubble  out  1  insert NOP into EX
flush_if_id  out  1  clear IF/ID register
fwd_sel_rs  out  FSEL_W  0 = register file, k = from scoreboard entry k-1
fwd_sel_rt  out  FSEL_W  as fwd_sel_rs, for rt
inflight_cnt  out  FSEL_W  valid scoreboard entries
done  out  1  drain complete

Behaviour:
- Reset (async, reset=0): scoreboard cleared, state=IDLE, inflight_cnt=0, done=0. Outputs during reset: stall=1, bubble=0, flush_if_id=0, fwd_sel_*=0.
- Scoreboard entry fields: {v, rd, wr, ld}. Every cycle entry[i+1] <= entry[i]. entry[0] <= decode instruction only when issued (RUN, id_valid, !stall, !ex_branch_taken); otherwise a bubble (v=0).
- A match on source s at entry k requires: v, wr, rd==s, s!=0 and the matching uses_* bit set. Register 0 never matches.
- Forwarding is combinational. The lowest-index matching entry wins (youngest writer): fwd_sel = k+1. No match gives 0.
- Load-use: the winning match has ld=1 and k<LOAD_LAT → stall=1 and bubble=1 for that cycle, fwd_sel=0. The check repeats each cycle, so the stall clears once the load moves past entry LOAD_LAT-1. Default: exactly one stall cycle.
- Branch: ex_branch_taken=1 in RUN → flush_if_id=1 and bubble=1; the decode instruction is not issued. The branch overrides any load-use stall in the same cycle, so stall=0 and fetch proceeds to the target. Combinational, single cycle.
- FSM:
  - IDLE: stall=1, no issue. valid=1 → RUN. opr_finished is ignored.
  - RUN: normal operation. opr_finished=1 → DRAIN; the instruction in decode that same cycle is still issued if otherwise allowed.
  - DRAIN: stall=1, bubble=1, no issue; forwarding still computed. inflight_cnt==0 → DONE.
  - DONE: done=1, stall=1. valid=1 → RUN with done cleared next cycle.
- valid and opr_finished high together in IDLE → RUN. In RUN, opr_finished takes priority and valid is ignored.
- Reset asserted mid-RUN or mid-DRAIN drops straight to IDLE with the scoreboard cleared asynchronously.
- inflight_cnt is a registered popcount of entry v bits, updated with the scoreboard.

Decomposition:
- Shared package (alongside ADDR_LINE_REG/D_SIZE): sb_entry_t struct {v, rd, wr, ld}, pipe_state_e enum {IDLE, RUN, DRAIN, DONE}, fwd-select encodings.
- One sub-module, fwd_match: pure priority match of one source against the scoreboard, returning {hit, idx, is_load_block}. Instantiated twice, for rs and rt.

Test Plan:
1. reset=0 then 1, valid=0 → stall=1, done=0, inflight_cnt=0; valid=1 → next cycle stall=0.
2. add r3←r1,r2 issued, next sub r4←r3,r5 in decode → fwd_sel_rs=1. One cycle later, with a bubble in between → fwd_sel_rs=2. r3 write to r0 → fwd_sel_rs=0.
3. lw r6 issued, next add uses r6 as rt → stall=1, bubble=1 for exactly 1 cycle, then fwd_sel_rt=2. With LOAD_LAT=2 → 2 stall cycles, then fwd_sel_rt=3.
4. Load-use stall and ex_branch_taken in the same cycle → stall=0, flush_if_id=1, bubble=1, no issue.
5. Three writers in flight, opr_finished=1 → DRAIN, inflight_cnt counts 3,2,1,0, then done=1. valid=1 → RUN, done=0.
6. reset pulsed low while in DRAIN with inflight_cnt=2 → immediately inflight_cnt=0, stall=1, state IDLE.
